shift_pipe_unit: RTL
====================

Name: shift_pipe_unit

Overview:
Two-stage pipelined shift execution unit for the EX stage. It accepts one shift operation per cycle from issue/decode over a valid/ready handshake. The operation is split into a coarse shift (multiples of 4) and a fine shift (0-3). Results leave in order, with a destination tag, to the writeback mux over a second valid/ready handshake.

Parameters:
DATA_WIDTH, 32, operand/result width in bits
NUM_WIDTH, 5, shift-amount width; must satisfy 2**NUM_WIDTH == DATA_WIDTH
TAG_WIDTH, 5, width of destination-register tag carried alongside the data

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
flush  input  1  synchronous pipeline kill (branch mispredict/exception)
in_valid  input  1  upstream operation valid
in_ready  output  1  unit can accept an operation this cycle
in_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 see Optional Feature
in_data  input  DATA_WIDTH  operand to shift
in_shamt  input  NUM_WIDTH  shift amount (unsigned)
in_tag  input  TAG_WIDTH  destination tag, passed through unmodified
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_data  output  DATA_WIDTH  shifted result
out_tag  output  TAG_WIDTH  tag belonging to out_data

Behaviour:
- Reset (async, rst=1): s1_valid=0, s2_valid=0. All stage data, tag, op and shamt registers are cleared to 0. Outputs: out_valid=0, out_data=0, out_tag=0, in_ready=1 once rst deasserts.
- Stage 1 register captures a transfer when in_valid && in_ready.
  - Coarse-shifted data: in_data shifted by {in_shamt[NUM_WIDTH-1:2],2'b00}. SLL fills 0; SRL fills 0; SRA fills in_data[DATA_WIDTH-1].
  - Also captured: op, shamt[1:0], tag.
- Stage 2 register applies the fine shift by s1 shamt[1:0] using the same fill rules.
  - SRA fill bit is the MSB of the stage-1 data, which is already sign-correct.
- Latency: result visible on out_* exactly 2 cycles after acceptance when out_ready stays 1. Throughput is 1 op/cycle.
- out_* are driven directly from stage-2 registers; no combinational path from in_* to out_*.
- Advance rules:
  - s2_adv = s1_valid && (!s2_valid || out_ready)
  - in_ready = !s1_valid || s2_adv (combinational from out_ready; intentional, no skid buffer)
  - s2_valid next = s1_valid when s2_adv; else 0 when out_ready; else hold
  - s1_valid next = in_valid when in_ready; else hold
- Backpressure: with out_ready=0, the pipeline holds at most 2 ops; in_ready drops once both stages are full. Data and tag registers hold steady while stalled; ordering is strictly preserved.
- Flush: when flush=1 at a rising edge, s1_valid and s2_valid go to 0.
  - Any input handshaking in the same cycle is discarded.
  - A result with out_valid&&out_ready in the flush cycle counts as consumed (downstream already sampled it).
  - Data registers need not clear.
- shamt=0: result equals in_data for every op.
- shamt=DATA_WIDTH-1: full range is supported; no masking beyond NUM_WIDTH bits.
- Reset mid-operation: all in-flight ops are lost; no partial output.

Optional Feature:
Macro SHIFT_ROTATE_EN.
- Defined: in_op=11 is rotate-left. Coarse stage rotates by shamt&~3, fine stage by shamt[1:0], with bits wrapping from MSB to LSB.
- Undefined: in_op=11 passes in_data through unchanged, with the same latency and handshake; no rotate logic is synthesized.

Test Plan:
1. SLL: in_data=0x00000001, shamt=31, out_ready=1 -> out_data=0x80000000 exactly 2 cycles after accept; out_tag echoes in_tag=5'd7.
2. SRA/SRL: SRA 0x80000000 by 4 -> 0xF8000000; SRL 0xF0000000 by 28 -> 0x0000000F; SRA 0x7FFFFFF0 by 3 -> 0x0FFFFFFE.
3. Back-to-back: issue 4 ops on consecutive cycles with out_ready=1 -> 4 results on 4 consecutive cycles in issue order; in_ready stays 1 throughout.
4. Backpressure: out_ready=0, offer 3 ops -> first 2 accepted, in_ready=0 on the third; raise out_ready -> results emerge in order with no loss or duplication.
5. Flush: both stages full, flush=1 for one cycle -> out_valid=0 the next cycle; a new op is then accepted and appears 2 cycles later.
6. Rotate: in_op=11, in_data=0x80000001, shamt=5 -> 0x00000030 with SHIFT_ROTATE_EN defined; 0x80000001 (pass-through) without it. Also assert rst mid-stream -> out_valid=0 immediately (async).

Source files
------------

// File: rtl/shift_pipe_unit_if.sv
// Handshake bundle between issue/decode, the shift unit and the writeback mux.
// master = the pipeline surroundings (issue side + writeback side), slave = the unit.
interface shift_pipe_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WIDTH  = 5,
    parameter int TAG_WIDTH  = 5
);
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            in_op;
    logic [DATA_WIDTH-1:0] in_data;
    logic [NUM_WIDTH-1:0]  in_shamt;
    logic [TAG_WIDTH-1:0]  in_tag;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [TAG_WIDTH-1:0]  out_tag;

    modport master (
        output flush, in_valid, in_op, in_data, in_shamt, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  flush, in_valid, in_op, in_data, in_shamt, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/shift_pipe_unit.sv
// Two-stage shift unit: stage 1 does the coarse shift (multiples of 4),
// stage 2 the fine shift (0-3). Results leave in order with their tag.
// Optional macro SHIFT_ROTATE_EN: op 11 becomes rotate-left; without it
// op 11 is a pass-through and no rotate logic exists.
module shift_pipe_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WIDTH  = 5,
    parameter int TAG_WIDTH  = 5
) (
    input  logic       clk,
    input  logic       rst,
    shift_pipe_if.slave io_bus
);

    // Shared shifter used by both stages; the fill rules are identical,
    // only the amount differs. SRA fill is the current MSB, which after
    // stage 1 is still the original sign bit.
    function automatic logic [DATA_WIDTH-1:0] f_shift(
        input logic [1:0]            op,
        input logic [DATA_WIDTH-1:0] d,
        input logic [NUM_WIDTH-1:0]  amt
    );
`ifdef SHIFT_ROTATE_EN
        logic [2*DATA_WIDTH-1:0] dd;
        dd = {d, d} << amt;
`endif
        case (op)
            2'b00:   f_shift = d << amt;
            2'b01:   f_shift = d >> amt;
            2'b10:   f_shift = $signed(d) >>> amt;
`ifdef SHIFT_ROTATE_EN
            default: f_shift = dd[2*DATA_WIDTH-1:DATA_WIDTH];
`else
            default: f_shift = d;
`endif
        endcase
    endfunction

    logic                  r_s1_valid;
    logic [1:0]            r_s1_op;
    logic [DATA_WIDTH-1:0] r_s1_data;
    logic [1:0]            r_s1_shamt;
    logic [TAG_WIDTH-1:0]  r_s1_tag;
    logic                  r_s2_valid;
    logic [DATA_WIDTH-1:0] r_s2_data;
    logic [TAG_WIDTH-1:0]  r_s2_tag;

    logic                  w_s2_adv;
    logic                  w_in_ready;
    logic                  w_in_fire;
    logic [NUM_WIDTH-1:0]  w_coarse_amt;
    logic [NUM_WIDTH-1:0]  w_fine_amt;

    // in_ready depends combinationally on out_ready: no skid buffer, so a
    // full pipe only accepts when the head is leaving this cycle.
    assign w_s2_adv     = r_s1_valid && (!r_s2_valid || io_bus.out_ready);
    assign w_in_ready   = !r_s1_valid || w_s2_adv;
    assign w_in_fire    = io_bus.in_valid && w_in_ready;
    assign w_coarse_amt = {io_bus.in_shamt[NUM_WIDTH-1:2], 2'b00};
    assign w_fine_amt   = {{(NUM_WIDTH-2){1'b0}}, r_s1_shamt};

    assign io_bus.in_ready  = w_in_ready;
    assign io_bus.out_valid = r_s2_valid;
    assign io_bus.out_data  = r_s2_data;
    assign io_bus.out_tag   = r_s2_tag;

    // Stage 1: valid tracking with flush kill, coarse shift on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_data  <= '0;
            r_s1_shamt <= '0;
            r_s1_tag   <= '0;
        end else begin
            if (io_bus.flush)
                r_s1_valid <= 1'b0;
            else if (w_in_ready)
                r_s1_valid <= io_bus.in_valid;
            if (w_in_fire) begin
                r_s1_op    <= io_bus.in_op;
                r_s1_data  <= f_shift(io_bus.in_op, io_bus.in_data, w_coarse_amt);
                r_s1_shamt <= io_bus.in_shamt[1:0];
                r_s1_tag   <= io_bus.in_tag;
            end
        end
    end

    // Stage 2: fine shift on advance; drains when downstream takes the head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_tag   <= '0;
        end else begin
            if (io_bus.flush)
                r_s2_valid <= 1'b0;
            else if (w_s2_adv)
                r_s2_valid <= 1'b1;
            else if (io_bus.out_ready)
                r_s2_valid <= 1'b0;
            if (w_s2_adv) begin
                r_s2_data <= f_shift(r_s1_op, r_s1_data, w_fine_amt);
                r_s2_tag  <= r_s1_tag;
            end
        end
    end

endmodule
